// File: rtl/spi_id_responder.sv
// spi_id_responder
// SPI mode-0 slave that stands in for the identification side of a serial NOR
// flash. It answers JEDEC Read-ID (0x9F) with {ID0,ID1,ID2} followed by 0xFF
// bytes, and Read-Status (0x05) with STATUS repeated. Every other command is
// ignored until chip select is released. All logic runs on clk12MHz. The SPI
// pins are oversampled, and sck is never used as a clock.
//
// Ports:
//   clk12MHz     - system clock, the only clock
//   rst          - synchronous, active-high reset
//   sck          - SPI clock from the master, idles low
//   cs           - chip select, active-low
//   sdi          - master-to-slave data (MOSI)
//   sdo          - slave-to-master data (MISO), changes only on sck fall
//   cmd_out      - last complete command byte received
//   cmd_valid    - one-cycle pulse when cmd_out is updated
//   debug_states - current state code (IDLE=0 CMD=1 RESP_ID=2 RESP_ST=3 IGNORE=4)
module spi_id_responder #(
  parameter logic [7:0] ID0    = 8'hEF,
  parameter logic [7:0] ID1    = 8'h40,
  parameter logic [7:0] ID2    = 8'h16,
  parameter logic [7:0] STATUS = 8'h00
) (
  input  logic       clk12MHz,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       sdi,
  output logic       sdo,
  output logic [7:0] cmd_out,
  output logic       cmd_valid,
  output logic [3:0] debug_states
);

  localparam int unsigned CMD_W  = 8;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned TX_W   = 24;
  localparam int unsigned TCNT_W = 5;
  localparam int unsigned ST_W   = 4;

  localparam logic [CMD_W-1:0] CMD_RDID = 8'h9F;
  localparam logic [CMD_W-1:0] CMD_RDSR = 8'h05;

  localparam logic [TCNT_W-1:0] ID_BITS = TCNT_W'(24);
  localparam logic [TCNT_W-1:0] ST_BITS = TCNT_W'(8);

  localparam logic [ST_W-1:0] S_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] S_CMD     = 4'd1;
  localparam logic [ST_W-1:0] S_RESP_ID = 4'd2;
  localparam logic [ST_W-1:0] S_RESP_ST = 4'd3;
  localparam logic [ST_W-1:0] S_IGNORE  = 4'd4;

  // Pin synchronizers, third sck stage and registered edge strobes
  logic sck_s1, sck_s2, sck_s3;
  logic cs_s1, cs_s2;
  logic sdi_s1, sdi_s2;
  logic rise, fall;

  // Counts synchronizer fill after reset; cs_s2 reflects the pin once ready
  logic [1:0] fill_cnt;
  logic       ready;
  logic       armed;

  logic [ST_W-1:0] state_q, state_nxt;

  logic [CMD_W-1:0]  shift_q, shift_nxt;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_nxt;
  logic [TX_W-1:0]   tx_sr_q, tx_sr_nxt;
  logic [TCNT_W-1:0] tx_cnt_q, tx_cnt_nxt;
  logic              loaded_q, loaded_nxt;
  logic              sdo_nxt;
  logic [CMD_W-1:0]  cmd_out_nxt;
  logic              cmd_valid_nxt;

  logic [CMD_W-1:0]  cmd_byte_c;
  logic              last_bit_c;

  assign ready      = (fill_cnt == 2'd2);
  assign cmd_byte_c = {shift_q[CMD_W-2:0], sdi_s2};
  assign last_bit_c = (bit_cnt_q == BCNT_W'(7));

  // Synchronizers load idle levels on reset
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_s3   <= 1'b0;
      cs_s1    <= 1'b1;
      cs_s2    <= 1'b1;
      sdi_s1   <= 1'b0;
      sdi_s2   <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      fill_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      sck_s1   <= sck;
      sck_s2   <= sck_s1;
      sck_s3   <= sck_s2;
      cs_s1    <= cs;
      cs_s2    <= cs_s1;
      sdi_s1   <= sdi;
      sdi_s2   <= sdi_s1;
      rise     <= sck_s2 & ~sck_s3;
      fall     <= ~sck_s2 & sck_s3;
      if (!ready) begin
        fill_cnt <= 2'(fill_cnt + 2'd1);
      end
      // Goes high one cycle after the first valid cs sample
      armed    <= ready;
    end
  end

  // State register
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; a high cs always wins over a coincident sck edge
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        // cs already low on the first valid sample means we woke up mid-transfer
        if (ready && !cs_s2) begin
          state_nxt = armed ? S_CMD : S_IGNORE;
        end
      end
      S_CMD: begin
        if (cs_s2) begin
          state_nxt = S_IDLE;
        end else if (rise && last_bit_c) begin
          if (cmd_byte_c == CMD_RDID) begin
            state_nxt = S_RESP_ID;
          end else if (cmd_byte_c == CMD_RDSR) begin
            state_nxt = S_RESP_ST;
          end else begin
            state_nxt = S_IGNORE;
          end
        end
      end
      S_RESP_ID, S_RESP_ST, S_IGNORE: begin
        if (cs_s2) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shift_nxt     = shift_q;
    bit_cnt_nxt   = bit_cnt_q;
    tx_sr_nxt     = tx_sr_q;
    tx_cnt_nxt    = tx_cnt_q;
    loaded_nxt    = loaded_q;
    sdo_nxt       = sdo;
    cmd_out_nxt   = cmd_out;
    cmd_valid_nxt = 1'b0;

    case (state_q)
      S_IDLE: begin
        shift_nxt   = '0;
        bit_cnt_nxt = '0;
        tx_cnt_nxt  = '0;
        loaded_nxt  = 1'b0;
        sdo_nxt     = 1'b0;
      end
      S_CMD: begin
        sdo_nxt = 1'b0;
        if (rise) begin
          shift_nxt   = cmd_byte_c;
          bit_cnt_nxt = BCNT_W'(bit_cnt_q + BCNT_W'(1));
          if (last_bit_c) begin
            cmd_out_nxt   = cmd_byte_c;
            cmd_valid_nxt = 1'b1;
          end
        end
      end
      S_RESP_ID: begin
        if (fall) begin
          if (!loaded_q) begin
            tx_sr_nxt  = {ID0, ID1, ID2};
            sdo_nxt    = ID0[7];
            tx_cnt_nxt = TCNT_W'(1);
            loaded_nxt = 1'b1;
          end else if (tx_cnt_q < ID_BITS) begin
            sdo_nxt    = tx_sr_q[TX_W-2];
            tx_sr_nxt  = {tx_sr_q[TX_W-2:0], 1'b0};
            tx_cnt_nxt = TCNT_W'(tx_cnt_q + TCNT_W'(1));
          end else begin
            // ID exhausted: master reads 0xFF from here on
            sdo_nxt = 1'b1;
          end
        end
      end
      S_RESP_ST: begin
        if (fall) begin
          // Status byte sits in the top 8 bits so the shift path is shared
          if (!loaded_q || (tx_cnt_q == ST_BITS)) begin
            tx_sr_nxt  = {STATUS, 16'h0000};
            sdo_nxt    = STATUS[7];
            tx_cnt_nxt = TCNT_W'(1);
            loaded_nxt = 1'b1;
          end else begin
            sdo_nxt    = tx_sr_q[TX_W-2];
            tx_sr_nxt  = {tx_sr_q[TX_W-2:0], 1'b0};
            tx_cnt_nxt = TCNT_W'(tx_cnt_q + TCNT_W'(1));
          end
        end
      end
      S_IGNORE: begin
        sdo_nxt = 1'b0;
      end
      default: begin
        sdo_nxt = 1'b0;
      end
    endcase

    // Deselect discards any partial byte and suppresses a same-cycle cmd_valid
    if (cs_s2) begin
      shift_nxt     = '0;
      bit_cnt_nxt   = '0;
      tx_cnt_nxt    = '0;
      loaded_nxt    = 1'b0;
      sdo_nxt       = 1'b0;
      cmd_out_nxt   = cmd_out;
      cmd_valid_nxt = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      tx_cnt_q  <= '0;
      loaded_q  <= 1'b0;
      sdo       <= 1'b0;
      cmd_out   <= '0;
      cmd_valid <= 1'b0;
    end else begin
      shift_q   <= shift_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      tx_sr_q   <= tx_sr_nxt;
      tx_cnt_q  <= tx_cnt_nxt;
      loaded_q  <= loaded_nxt;
      sdo       <= sdo_nxt;
      cmd_out   <= cmd_out_nxt;
      cmd_valid <= cmd_valid_nxt;
    end
  end

  assign debug_states = state_q;

endmodule

// File: doc/spi_id_responder.md
# spi_id_responder

SPI mode-0 slave that emulates the identification side of a serial NOR flash. It answers JEDEC Read-ID (0x9F) and Read-Status (0x05) commands from the flash-ID master, so the master can be exercised on the board or in simulation without a real flash part. All logic runs on the system clock: the SPI pins are oversampled through synchronizers, and no logic is clocked by `sck`.

## Interface
- `ID0`, 8'hEF: manufacturer ID byte, sent first.
- `ID1`, 8'h40: memory-type byte, sent second.
- `ID2`, 8'h16: capacity byte, sent third.
- `STATUS`, 8'h00: value returned repeatedly for command 0x05.
- `clk12MHz` input 1: system clock, the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `sck` input 1: SPI clock from the master, idles low.
- `cs` input 1: chip select, active-low.
- `sdi` input 1: master-to-slave data (MOSI).
- `sdo` output 1: slave-to-master data (MISO).
- `cmd_out` output 8: last complete command byte received.
- `cmd_valid` output 1: one-cycle pulse when `cmd_out` is updated.
- `debug_states` output 4: current state code, for the LED matrix.

## Operation
- **Synchronizers.** `sck`, `cs` and `sdi` each pass through 2 flops. On reset these flops load the idle levels: sck=0, cs=1, sdi=0.
- **Edge detect.** A third `sck` flop gives one-cycle `rise` and `fall` strobes.
- **Bit order and mode.** MSB first. `sdi` is sampled on `rise`; `sdo` changes only on `fall`.
- **State codes** (`debug_states`): IDLE=0, CMD=1, RESP_ID=2, RESP_ST=3, IGNORE=4.
- **IDLE.** `sdo`=0 and the bit counter is 0. A synchronized `cs` low moves to CMD.
- **CMD.**
  - Each `rise` shifts `sdi` into an 8-bit register and increments a 3-bit counter.
  - On the 8th `rise`: `cmd_out` takes the full byte and `cmd_valid` pulses for 1 cycle.
  - Next state: 0x9F → RESP_ID; 0x05 → RESP_ST; any other value → IGNORE.
- **RESP_ID.**
  - On the first `fall` after entry, load the 24-bit shift register with {ID0,ID1,ID2} and drive `sdo`=ID0[7].
  - Each later `fall` shifts left by one.
  - After 24 bits have been sent, `sdo`=1 (0xFF bytes) until `cs` goes high.
- **RESP_ST.** Same load-and-shift scheme with an 8-bit register holding STATUS, reloaded every 8 bits. STATUS repeats until `cs` goes high.
- **IGNORE.** `sdo`=0 and all edges are ignored until `cs` goes high.
- **Any state, `cs` high** (synchronized): next cycle is IDLE, `sdo`=0, counters cleared. A partial command byte is discarded with no `cmd_valid`.
- **Reset** (any state, mid-transfer included):
  - State goes to IDLE; `sdo`, `cmd_out`, `cmd_valid` and `debug_states` all go to 0.
  - If synchronized `cs` is low on the first cycle after reset, enter IGNORE instead of CMD. This prevents joining a transfer mid-byte.
- **Same-cycle `rise` and `cs` going high:** `cs` wins; the edge is discarded.

## Timing
- Pin-to-strobe latency is 3 cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- `sdo` settles 4 cycles after an `sck` pin falling edge (strobe plus output register).
- Each `sck` half-period must be ≥6 `clk12MHz` cycles, so sck ≤1 MHz. Faster `sck` is unsupported and its behaviour is undefined.
- `cs` low to first `sck` rise: ≥4 cycles. Last `sck` fall to `cs` high: ≥4 cycles.
- `cmd_valid` asserts 4 cycles after the 8th `sck` rising edge at the pin and lasts exactly 1 cycle.
- Output reset values: `sdo`=0, `cmd_out`=8'h00, `cmd_valid`=0, `debug_states`=4'd0.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `cs`=1 → all outputs 0 and `debug_states`=0. With `cs` held low during reset → `debug_states`=4 and `sdo` stays 0 for 16 clocks.
- **JEDEC ID.** Send 0x9F, then 24 clocks at 500 kHz → master samples 0xEF, 0x40, 0x16. `cmd_out`=0x9F with exactly one `cmd_valid` pulse. 8 more clocks → 0xFF.
- **Status.** Send 0x05, then 16 clocks with STATUS=8'hA5 → 0xA5, 0xA5; `debug_states`=3.
- **Unknown command.** Send 0x03, then 8 clocks → `sdo`=0 throughout, `debug_states`=4, `cmd_out`=0x03.
- **Abort mid-command.** `cs` high after 5 bits of 0x9F → no `cmd_valid`, return to IDLE. A following full 0x9F transfer still returns 0xEF40_16.
- **Reset mid-response.** Assert `rst` after 10 ID bits → `sdo`=0 on the next cycle. Raise `cs`, then issue a new 0x9F → full correct ID.
